tdm_mux: RTL and testbench

TDM_MUX -- requirements
Module: tdm_mux

---
 rtl/tdm_mux_pkg.sv | 27 ++
 rtl/rr_next_ch.sv | 40 ++++
 rtl/tdm_mux.sv | 140 ++++++++++++++
 tb/tb_tdm_mux.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_mux_pkg.sv
// tdm_mux_pkg: shared definitions for the TDM multiplexer slice.
//   state_t    - controller states (idle, manual select, auto-scan)
//   MODE_*     - encodings of the mode input
//   tdm_clog2  - ceiling log2 used for select / counter widths (min 1)
package tdm_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAN  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic MODE_MAN  = 1'b0;
  localparam logic MODE_AUTO = 1'b1;

  // Width needed to hold values 0..n-1; never narrower than one bit.
  function automatic int tdm_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < n) r = i + 1;
      else r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_next_ch.sv
// rr_next_ch: combinational round-robin search over an enable mask.
//   cur_ch    - channel currently being served
//   ch_en     - per-channel enable mask
//   next_ch   - first enabled channel above cur_ch, else lowest enabled
//   wrapped   - 1 when the search had to wrap to the lowest enabled channel
//   lowest_ch - lowest enabled channel (0 when the mask is empty)
module rr_next_ch
  import tdm_mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [tdm_clog2(N_CH)-1:0] cur_ch,
  input  logic [N_CH-1:0]            ch_en,
  output logic [tdm_clog2(N_CH)-1:0] next_ch,
  output logic                       wrapped,
  output logic [tdm_clog2(N_CH)-1:0] lowest_ch
);

  localparam int SEL_W = tdm_clog2(N_CH);

  logic [SEL_W-1:0] hi_s;
  logic             hi_found_s;
  logic [SEL_W-1:0] low_s;

  // Scan from the top down so the lowest qualifying index is the one kept.
  always_comb begin
    hi_s       = '0;
    hi_found_s = 1'b0;
    low_s      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      hi_s       = (ch_en[k] && (k > int'(cur_ch))) ? SEL_W'(k) : hi_s;
      hi_found_s = hi_found_s | (ch_en[k] && (k > int'(cur_ch)));
      low_s      = ch_en[k] ? SEL_W'(k) : low_s;
    end
    next_ch   = hi_found_s ? hi_s : low_s;
    wrapped   = ~hi_found_s;
    lowest_ch = low_s;
  end

endmodule

// File: rtl/tdm_mux.sv
// tdm_mux: time-division multiplexer with manual select and auto-scan.
//   clk, rst_n  - clock, asynchronous active-low reset
//   in          - flat bus, channel k at bits [k*W +: W]
//   sel         - manual channel select
//   mode        - 0 manual, 1 auto-scan
//   ch_en       - auto-scan channel enable mask
//   out         - registered selected data
//   out_ch      - channel index driving out
//   out_valid   - out/out_ch carry a legal selection
//   frame_start - pulse when the scan starts over at the lowest enabled channel
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH*W-1:0]          in,
  input  logic [tdm_clog2(N_CH)-1:0] sel,
  input  logic                       mode,
  input  logic [N_CH-1:0]            ch_en,
  output logic [W-1:0]               out,
  output logic [tdm_clog2(N_CH)-1:0] out_ch,
  output logic                       out_valid,
  output logic                       frame_start
);

  localparam int SEL_W = tdm_clog2(N_CH);
  localparam int CNT_W = tdm_clog2(DWELL);

  state_t           state_r, state_d;
  logic [CNT_W-1:0] cnt_r, cnt_d;
  logic [SEL_W-1:0] cur_ch_r, cur_ch_d;
  logic [SEL_W-1:0] och_d;
  logic             vld_d;
  logic             fs_d;
  logic [W-1:0]     data_d;

  logic [SEL_W-1:0] next_ch_s;
  logic             wrapped_s;
  logic [SEL_W-1:0] lowest_s;
  logic             sel_ok_s;

  rr_next_ch #(.N_CH(N_CH)) u_next (
    .cur_ch    (cur_ch_r),
    .ch_en     (ch_en),
    .next_ch   (next_ch_s),
    .wrapped   (wrapped_s),
    .lowest_ch (lowest_s)
  );

  assign sel_ok_s = (int'(sel) < N_CH);

  // Next-state decode; the outputs follow the channel chosen at this same edge.
  always_comb begin
    state_d  = state_r;
    cnt_d    = cnt_r;
    cur_ch_d = cur_ch_r;
    och_d    = '0;
    vld_d    = 1'b0;
    fs_d     = 1'b0;
    case (mode)
      MODE_MAN: begin
        state_d = ST_MAN;
        cnt_d   = '0;
        if (sel_ok_s) begin
          och_d = sel;
          vld_d = 1'b1;
        end else begin
          och_d = '0;
          vld_d = 1'b0;
        end
      end
      MODE_AUTO: begin
        if (ch_en == '0) begin
          // Nothing to scan: park, keep cur_ch, outputs stay cleared.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_SCAN;
          vld_d   = 1'b1;
          case (state_r)
            ST_SCAN: begin
              if (cnt_r == CNT_W'(DWELL - 1)) begin
                cur_ch_d = next_ch_s;
                cnt_d    = '0;
                fs_d     = wrapped_s;
              end else begin
                cnt_d = cnt_r + CNT_W'(1);
              end
            end
            default: begin
              // Entry from idle or manual starts a fresh frame.
              cur_ch_d = lowest_s;
              cnt_d    = '0;
              fs_d     = 1'b1;
            end
          endcase
          och_d = cur_ch_d;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Data select for the chosen channel; zero when the selection is not valid.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      data_d = (vld_d && (och_d == SEL_W'(k))) ? in[k*W +: W] : data_d;
    end
  end

  // State, dwell counter, current channel and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      cur_ch_r    <= '0;
      out         <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_d;
      cnt_r       <= cnt_d;
      cur_ch_r    <= cur_ch_d;
      out         <= data_d;
      out_ch      <= och_d;
      out_valid   <= vld_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux.sv
// tb_tdm_mux: scoreboard bench. Two instances share stimulus:
//   dut0: N_CH=4, W=8, DWELL=4   dut1: N_CH=3, W=8, DWELL=1
module tb_tdm_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  ch_en;

  logic [7:0] out0, out1;
  logic [1:0] och0, och1;
  logic       v0, v1, fs0, fs1;

  always #5 clk = ~clk;

  tdm_mux #(.N_CH(4), .W(8), .DWELL(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(din), .sel(sel), .mode(mode), .ch_en(ch_en),
    .out(out0), .out_ch(och0), .out_valid(v0), .frame_start(fs0)
  );

  tdm_mux #(.N_CH(3), .W(8), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(din[23:0]), .sel(sel), .mode(mode), .ch_en(ch_en[2:0]),
    .out(out1), .out_ch(och1), .out_valid(v1), .frame_start(fs1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
    logic       v;
    logic       fs;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: scanning?, channel being served, cycles left on it.
  bit act[2];
  int cur[2];
  int left[2];

  function automatic int lowest_en(input logic [3:0] en, input int n);
    for (int k = 0; k < n; k++) if (en[k]) return k;
    return 0;
  endfunction

  task automatic model_step(input int id, input int n, input int dwell, input logic r,
                            input logic md, input logic [1:0] s, input logic [3:0] en_in,
                            input logic [31:0] d, output exp_t e);
    logic [3:0] en;
    int nx;
    en = en_in & ((4'd1 << n) - 4'd1);
    e = '0;
    if (!r) begin
      act[id] = 1'b0;
    end else if (!md) begin
      act[id] = 1'b0;
      if (int'(s) < n) begin
        e.v  = 1'b1;
        e.ch = s;
        e.d  = 8'(d >> (8 * int'(s)));
      end
    end else if (en == 4'd0) begin
      act[id] = 1'b0;
    end else begin
      if (!act[id]) begin
        act[id]  = 1'b1;
        cur[id]  = lowest_en(en, n);
        left[id] = dwell - 1;
        e.fs     = 1'b1;
      end else if (left[id] > 0) begin
        left[id] = left[id] - 1;
      end else begin
        nx = -1;
        for (int k = cur[id] + 1; k < n; k++) if (en[k] && nx < 0) nx = k;
        if (nx < 0) begin
          nx   = lowest_en(en, n);
          e.fs = 1'b1;
        end
        cur[id]  = nx;
        left[id] = dwell - 1;
      end
      e.v  = 1'b1;
      e.ch = 2'(cur[id]);
      e.d  = 8'(d >> (8 * cur[id]));
    end
  endtask

  task automatic check(input string nm, input exp_t got, input exp_t ex);
    n_vec++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL %s t=%0t got d=%h ch=%0d v=%b fs=%b, expected d=%h ch=%0d v=%b fs=%b",
               nm, $time, got.d, got.ch, got.v, got.fs, ex.d, ex.ch, ex.v, ex.fs);
    end
  endtask

  // Apply one cycle of stimulus and queue what each instance must show after the edge.
  task automatic drive(input logic r, input logic md, input logic [1:0] s,
                       input logic [3:0] en, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    rst_n = r; mode = md; sel = s; ch_en = en; din = d;
    model_step(0, 4, 4, r, md, s, en, d, e);
    q0.push_back(e);
    model_step(1, 3, 1, r, md, s, en, d, e);
    q1.push_back(e);
  endtask

  // Assert reset between edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dut0", {out0, och0, v0, fs0}, '0);
    check("async_rst_dut1", {out1, och1, v1, fs1}, '0);
    act[0] = 1'b0;
    act[1] = 1'b0;
    drive(1'b0, 1'b1, 2'd0, 4'hF, 32'h0);
  endtask

  // Monitor: every cycle each instance presents a result; pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) check("dut0", {out0, och0, v0, fs0}, q0.pop_front());
      if (q1.size() > 0) check("dut1", {out1, och1, v1, fs1}, q1.pop_front());
    end
  end

  initial begin
    logic       md;
    logic [3:0] en;
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; ch_en = 4'h0; din = 32'h0;
    #1;
    check("reset_dut0", {out0, och0, v0, fs0}, '0);
    check("reset_dut1", {out1, och1, v1, fs1}, '0);
    repeat (2) drive(1'b0, 1'b0, 2'd0, 4'h0, 32'h0);

    // Manual select sweep; sel=3 is out of range for the 3-channel instance.
    for (int s = 0; s < 4; s++) drive(1'b1, 1'b0, 2'(s), 4'h0, 32'hD4C3B2A1);
    drive(1'b1, 1'b0, 2'd2, 4'h0, 32'hD4C3B2A1);

    // Auto-scan: full mask, sparse mask, empty mask, single channel.
    repeat (20) drive(1'b1, 1'b1, 2'd0, 4'hF, 32'($urandom));
    repeat (12) drive(1'b1, 1'b1, 2'd0, 4'hA, 32'($urandom));
    repeat (3)  drive(1'b1, 1'b1, 2'd0, 4'h0, 32'($urandom));
    repeat (6)  drive(1'b1, 1'b1, 2'd0, 4'h4, 32'($urandom));
    repeat (10) drive(1'b1, 1'b1, 2'd0, 4'h1, 32'($urandom));

    // Reset in the middle of the channel-2 dwell, then restart on a new mask.
    drive(1'b1, 1'b0, 2'd1, 4'hF, 32'($urandom));
    repeat (10) drive(1'b1, 1'b1, 2'd0, 4'hF, 32'($urandom));
    async_reset();
    repeat (10) drive(1'b1, 1'b1, 2'd0, 4'hE, 32'($urandom));

    // Randomized mix of mode switches, mask changes and resets.
    md = 1'b1;
    en = 4'hF;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) md = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) en = 4'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      drive(1'b1, md, 2'($urandom), en, 32'($urandom));
    end

    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL drain got q0=%0d q1=%0d pending, expected 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
